// File: rtl/eb_ser.sv
// Width-down serializer: takes one wide word per input handshake and emits it
// as RATIO narrow beats, least-significant slice first, with a last-beat flag.
module eb_ser #(
  parameter int unsigned I_0_WIDTH = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned T_0_WIDTH = I_0_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [T_0_WIDTH-1:0] t_0_data,
  input  logic                 t_0_valid,
  output logic                 t_0_ready,
  output logic [I_0_WIDTH-1:0] i_0_data,
  output logic                 i_0_valid,
  output logic                 i_0_last,
  input  logic                 i_0_ready
);

  localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 1) begin : g_bad_ratio
    $error("eb_ser: RATIO must be at least 1");
  end
  if (T_0_WIDTH != I_0_WIDTH * RATIO) begin : g_bad_width
    $error("eb_ser: T_0_WIDTH must equal I_0_WIDTH*RATIO");
  end

  typedef enum logic {
    StEmpty = 1'b0,
    StSend  = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [RATIO-1:0][I_0_WIDTH-1:0]   hold_q, hold_d;
  logic                              full;
  logic                              last_beat;

  assign full      = (state_q == StSend);
  assign last_beat = (cnt_q == CntW'(RATIO - 1));

  assign i_0_valid = full;
  assign i_0_last  = full & last_beat;
  // Only combinational path through the block: i_0_ready -> t_0_ready.
  assign t_0_ready = ~full | (i_0_last & i_0_ready);

  // Beat mux selects a slice of the held word; purely registered inputs.
  if (RATIO == 1) begin : g_single
    assign i_0_data = hold_q[0];
  end else begin : g_multi
    assign i_0_data = hold_q[cnt_q];
  end

  // Next-state logic for the EMPTY/SEND controller, counter and hold register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StEmpty: begin
        if (t_0_valid) begin
          hold_d  = t_0_data;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_0_ready) begin
          if (!last_beat) begin
            cnt_d = cnt_q + CntW'(1);
          end else if (t_0_valid) begin
            // Back-to-back reload on the last beat keeps full throughput.
            hold_d = t_0_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = StEmpty;
          end
        end
      end
      default: begin
        state_d = StEmpty;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any partially sent word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule
